// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - immediate-format codes, opcode constants and decode entry type
package imm_pkg;

    localparam int IMM_PC_W = 32;

    localparam logic [2:0] IMM_I    = 3'b000;
    localparam logic [2:0] IMM_S    = 3'b001;
    localparam logic [2:0] IMM_B    = 3'b010;
    localparam logic [2:0] IMM_U    = 3'b011;
    localparam logic [2:0] IMM_J    = 3'b100;
    localparam logic [2:0] IMM_NONE = 3'b111;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // pc is sized by IMM_PC_W; the top's PC_W is expected to match it
    typedef struct packed {
        logic [2:0]          sign_type;
        logic [19:0]         number;
        logic [4:0]          number1;
        logic [6:0]          opcode;
        logic [IMM_PC_W-1:0] pc;
        logic                illegal;
    } imm_entry_t;

    function automatic logic [2:0] imm_classify(input logic [6:0] opcode);
        logic [2:0] t;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: t = IMM_I;
            OP_STORE:                            t = IMM_S;
            OP_BRANCH:                           t = IMM_B;
            OP_LUI, OP_AUIPC:                    t = IMM_U;
            OP_JAL:                              t = IMM_J;
            default:                             t = IMM_NONE;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/imm_field_decode_if.sv
// rtl/imm_field_decode_if.sv - fetch-side and extender-side handshake bundle
interface imm_field_decode_if #(
    parameter int PC_W      = 32,
    parameter int ILL_CNT_W = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_inst;
    logic [PC_W-1:0]      in_pc;
    logic                 out_valid;
    logic                 out_ready;
    logic [2:0]           out_sign_type;
    logic [19:0]          out_sign_number;
    logic [4:0]           out_sign_number1;
    logic [6:0]           out_opcode;
    logic [PC_W-1:0]      out_pc;
    logic                 out_illegal;
    logic [ILL_CNT_W-1:0] ill_count;

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_sign_type, out_sign_number,
               out_sign_number1, out_opcode, out_pc, out_illegal, ill_count
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_sign_type, out_sign_number,
               out_sign_number1, out_opcode, out_pc, out_illegal, ill_count
    );
endinterface

// File: rtl/imm_skid_buf.sv
// rtl/imm_skid_buf.sv - generic 2-entry valid/ready skid buffer with flush
module imm_skid_buf #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    // Encoding is {out_valid, ~in_ready} so both handshake outputs are flop bits
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t       state, state_nxt;
    logic [W-1:0] main_q, skid_q;
    logic         load_main_in, load_main_skid, load_skid;
    logic         accept, send;

    assign out_valid = state[1];
    assign in_ready  = ~state[0];
    assign out_data  = main_q;
    assign accept    = in_valid & in_ready;
    assign send      = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst) state <= EMPTY;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt    = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && send) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        state_nxt = FULL;
                        load_skid = 1'b1;
                    end else if (send) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (send) begin
                        state_nxt      = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            main_q <= RST_VAL;
            skid_q <= RST_VAL;
        end else begin
            if (load_main_in)        main_q <= in_data;
            else if (load_main_skid) main_q <= skid_q;
            if (load_skid)           skid_q <= in_data;
        end
    end

endmodule

// File: rtl/imm_field_decode.sv
// rtl/imm_field_decode.sv - registered opcode classify / immediate field slice stage
// Optional illegal-opcode flag and counter under IMM_DECODE_ILLEGAL_CHK_EN.
module imm_field_decode
    import imm_pkg::*;
#(
    parameter int PC_W      = IMM_PC_W,
    parameter int ILL_CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    imm_field_decode_if.slave io
);

    localparam int EW = $bits(imm_entry_t);
    localparam logic [EW-1:0] ENTRY_RST = {IMM_NONE, {(EW-3){1'b0}}};

    imm_entry_t in_ent, out_ent;
    logic       out_valid;

    always_comb begin
        in_ent           = '0;
        in_ent.sign_type = imm_classify(io.in_inst[6:0]);
        in_ent.number    = io.in_inst[31:12];
        in_ent.number1   = io.in_inst[11:7];
        in_ent.opcode    = io.in_inst[6:0];
        in_ent.pc        = IMM_PC_W'(io.in_pc);
`ifdef IMM_DECODE_ILLEGAL_CHK_EN
        // R-type is a legitimate "no immediate" instruction; anything else untyped is not
        in_ent.illegal   = ((in_ent.sign_type == IMM_NONE) && (io.in_inst[6:0] != OP_REG))
                           || (io.in_inst[1:0] != 2'b11);
`else
        in_ent.illegal   = 1'b0;
`endif
    end

    imm_skid_buf #(
        .W       (EW),
        .RST_VAL (ENTRY_RST)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (io.in_valid),
        .in_ready  (io.in_ready),
        .in_data   (in_ent),
        .out_valid (out_valid),
        .out_ready (io.out_ready),
        .out_data  (out_ent)
    );

    assign io.out_valid        = out_valid;
    assign io.out_sign_type    = out_ent.sign_type;
    assign io.out_sign_number  = out_ent.number;
    assign io.out_sign_number1 = out_ent.number1;
    assign io.out_opcode       = out_ent.opcode;
    assign io.out_pc           = PC_W'(out_ent.pc);

`ifdef IMM_DECODE_ILLEGAL_CHK_EN
    logic [ILL_CNT_W-1:0] ill_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ill_cnt_q <= '0;
        end else if (out_valid && io.out_ready && out_ent.illegal && (ill_cnt_q != '1)) begin
            ill_cnt_q <= ill_cnt_q + 1'b1;
        end
    end

    assign io.out_illegal = out_ent.illegal;
    assign io.ill_count   = ill_cnt_q;
`else
    assign io.out_illegal = 1'b0;
    assign io.ill_count   = {ILL_CNT_W{1'b0}};
`endif

endmodule

// File: doc/imm_field_decode.md
Name: imm_field_decode

Overview:
- Registered decode stage sitting directly upstream of the immediate sign-extension unit.
- Accepts fetched instructions over a valid/ready handshake and classifies the opcode into the 3-bit immediate-format code.
- Slices the raw immediate fields and presents them to the extender, already in its field layout, from a 2-entry skid buffer.
- Decouples fetch from execute stalls and supports a pipeline flush.

Parameters:
- PC_W, 32, width of the program counter carried alongside each instruction.
- ILL_CNT_W, 16, width of the illegal-instruction counter (optional feature only).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset.
- flush  input  1  discard all buffered entries (branch/jump redirect).
- in_valid  input  1  in_inst/in_pc valid.
- in_ready  output  1  stage can accept; registered, equals "skid entry empty".
- in_inst  input  32  raw instruction word.
- in_pc  input  PC_W  address of in_inst.
- out_valid  output  1  output entry valid.
- out_ready  input  1  downstream accepts.
- out_sign_type  output  3  000 I, 001 S, 010 B, 011 U, 100 J, 111 none/illegal.
- out_sign_number  output  20  inst[31:12].
- out_sign_number1  output  5  inst[11:7].
- out_opcode  output  7  inst[6:0].
- out_pc  output  PC_W  pc of the output entry.
- out_illegal  output  1  opcode not recognised; tied 0 without the optional feature.
- ill_count  output  ILL_CNT_W  illegal instructions delivered; tied 0 without the optional feature.

Behaviour:
- Reset (rst=0 at an edge): all entries invalid, out_valid=0, in_ready=1, every data output 0, out_sign_type=111, ill_count=0. Reset overrides flush and all handshakes.
- Opcode map:
  - 0000011, 0010011, 1100111, 1110011 -> 000
  - 0100011 -> 001
  - 1100011 -> 010
  - 0110111, 0010111 -> 011
  - 1101111 -> 100
  - 0110011 and all other opcodes -> 111
- Classification is done combinationally on in_inst and stored in the entry. Outputs are driven only from registers.
- Storage is a main entry (drives the outputs) plus a skid entry. States:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: out_valid=1, in_ready=1.
  - FULL: out_valid=1, in_ready=0.
- Accept occurs when in_valid&in_ready. Send occurs when out_valid&out_ready.
- Transitions:
  - EMPTY + accept -> ONE (main loaded). Latency is 1 cycle from accept to out_valid.
  - ONE + accept + no send -> FULL (skid loaded).
  - ONE + accept + send -> ONE (main reloaded with new data).
  - ONE + send only -> EMPTY.
  - FULL + send -> ONE (skid moves to main). No accept is possible because in_ready=0.
- Ordering: strict FIFO, and no entry is ever dropped or duplicated.
- Output stability: while out_valid=1 and out_ready=0, every out_* holds stable.
- Flush: on the next edge go to EMPTY and drop both entries, even if a send or accept happens in the same cycle. An in_inst presented in the flush cycle is discarded.
- in_valid while in_ready=0: ignored; upstream must hold its data.
- Field widths: fields are sliced exactly as stated; there is no sign extension in this stage.

Optional Feature:
- Macro: IMM_DECODE_ILLEGAL_CHK_EN.
- Defined:
  - out_illegal=1 for entries typed 111 whose opcode is not 0110011.
  - Also flags an entry illegal when inst[1:0]!=11.
  - ill_count increments by 1 on each send of an illegal entry and saturates at all-ones.
- Undefined: out_illegal and ill_count are constant 0, and no counter logic is present.

Decomposition:
- Shared package imm_pkg holds:
  - The 3-bit format constants (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE).
  - The 7-bit opcode constants.
  - A packed entry struct {sign_type, number, number1, opcode, pc, illegal}.
- Natural sub-module: imm_skid_buf, a generic 2-entry valid/ready skid buffer parameterised on payload width. The classifier stays in the top level.

Test Plan:
- Single addi x1,x0,-1 (0xFFF00093, pc 0x100), out_ready=1: next cycle out_valid=1, type 000, number 0xFFF00, number1 0x01, pc 0x100; then out_valid=0.
- sw x1,12(x2) (0x00112623): type 001, number 0x00112, number1 0x0C. Then jal 0x008000EF: type 100, number 0x00800, number1 0x01.
- Backpressure: out_ready=0, send beq 0x00208463, lui 0x123452B7, auipc 0x00000517 back-to-back:
  - in_ready=0 the cycle after the 2nd accept, and the 3rd instruction is held.
  - On out_ready=1, outputs appear in order with types 010, 011, 011.
- Flush in FULL (two entries buffered): next cycle out_valid=0, in_ready=1. The instruction presented during flush is not output.
- Reset mid-stream: rst=0 for one edge while FULL and out_ready toggling: all outputs return to reset values, and the next accepted instruction appears alone.
- With IMM_DECODE_ILLEGAL_CHK_EN: send 0x0000007F then add 0x002081B3:
  - First: type 111, out_illegal=1.
  - Second: type 111, out_illegal=0.
  - ill_count=1.
  - Without the macro, out_illegal and ill_count stay 0.
